// File: rtl/imm_ext_pkg.sv
// Shared types and opcode constants for the LEGv8 immediate extractor.
package imm_ext_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_D    = 3'd1,
      FMT_CB   = 3'd2,
      FMT_B    = 3'd3,
      FMT_I    = 3'd4,
      FMT_IW   = 3'd5
   } fmt_t;

   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [6:0]  OP_CB7  = 7'b1011010;
   localparam logic [5:0]  OP_B6   = 6'b000101;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [8:0]  OP_MOVZ = 9'b110100101;

endpackage

// File: rtl/imm_ext_pipe_decode.sv
// Combinational LEGv8 immediate decoder: instr -> {y, fmt}.
// Branch byte-offset scaling is enabled by IMM_EXT_BRANCH_SHL2_EN.
module imm_decode
   import imm_ext_pkg::*;
#(
   parameter int N = 64
) (
   input  logic [31:0]  instr,
   output logic [N-1:0] y,
   output fmt_t         fmt
);

   logic [63:0] wide_s;
   logic [63:0] movz_s;

   // MOVZ halfword placement; upper bits fall off when N < 64.
   always_comb begin
      movz_s = 64'd0;
      case (instr[22:21])
         2'd0:    movz_s = {48'd0, instr[20:5]};
         2'd1:    movz_s = {32'd0, instr[20:5], 16'd0};
         2'd2:    movz_s = {16'd0, instr[20:5], 32'd0};
         2'd3:    movz_s = {instr[20:5], 48'd0};
         default: movz_s = 64'd0;
      endcase
   end

   // Priority-ordered format match and extension to 64 bits.
   always_comb begin
      wide_s = 64'd0;
      fmt    = FMT_NONE;
      if ((instr[31:21] == OP_LDUR) || (instr[31:21] == OP_STUR)) begin
         wide_s = {{55{instr[20]}}, instr[20:12]};
         fmt    = FMT_D;
      end else if (instr[31:25] == OP_CB7) begin
`ifdef IMM_EXT_BRANCH_SHL2_EN
         wide_s = {{43{instr[23]}}, instr[23:5], 2'b00};
`else
         wide_s = {{45{instr[23]}}, instr[23:5]};
`endif
         fmt    = FMT_CB;
      end else if (instr[31:26] == OP_B6) begin
`ifdef IMM_EXT_BRANCH_SHL2_EN
         wide_s = {{36{instr[25]}}, instr[25:0], 2'b00};
`else
         wide_s = {{38{instr[25]}}, instr[25:0]};
`endif
         fmt    = FMT_B;
      end else if ((instr[31:22] == OP_ADDI) || (instr[31:22] == OP_SUBI)) begin
         wide_s = {52'd0, instr[21:10]};
         fmt    = FMT_I;
      end else if (instr[31:23] == OP_MOVZ) begin
         wide_s = movz_s;
         fmt    = FMT_IW;
      end else begin
         wide_s = 64'd0;
         fmt    = FMT_NONE;
      end
   end

   assign y = wide_s[N-1:0];

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extractor with a 2-entry valid/ready output queue.
// Optional branch byte-offset scaling: define IMM_EXT_BRANCH_SHL2_EN.
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int N     = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     y,
   output fmt_t             fmt,
   output logic [CNT_W-1:0] unk_cnt
);

   logic [N-1:0]     dec_y_s;
   fmt_t             dec_fmt_s;
   logic             push_s;
   logic             pop_s;

   logic [N-1:0]     head_y_r;
   fmt_t             head_fmt_r;
   logic [N-1:0]     tail_y_r;
   fmt_t             tail_fmt_r;
   logic [1:0]       count_r;
   logic [CNT_W-1:0] unk_r;

   imm_decode #(.N(N)) u_decode (
      .instr (instr),
      .y     (dec_y_s),
      .fmt   (dec_fmt_s)
   );

   assign in_ready  = !reset && (count_r != 2'd2);
   assign out_valid = (count_r != 2'd0);
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;
   assign y         = head_y_r;
   assign fmt       = head_fmt_r;
   assign unk_cnt   = unk_r;

   // Shift-style queue: head is always the oldest entry and drives the outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_y_r   <= '0;
         head_fmt_r <= FMT_NONE;
         tail_y_r   <= '0;
         tail_fmt_r <= FMT_NONE;
         count_r    <= 2'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (count_r == 2'd0) begin
                  head_y_r   <= dec_y_s;
                  head_fmt_r <= dec_fmt_s;
               end else begin
                  tail_y_r   <= dec_y_s;
                  tail_fmt_r <= dec_fmt_s;
               end
               count_r <= count_r + 2'd1;
            end
            2'b01: begin
               head_y_r   <= tail_y_r;
               head_fmt_r <= tail_fmt_r;
               count_r    <= count_r - 2'd1;
            end
            2'b11: begin
               // Only reachable at count 1: the new entry replaces the leaving head.
               if (count_r == 2'd1) begin
                  head_y_r   <= dec_y_s;
                  head_fmt_r <= dec_fmt_s;
               end else begin
                  head_y_r   <= tail_y_r;
                  head_fmt_r <= tail_fmt_r;
                  tail_y_r   <= dec_y_s;
                  tail_fmt_r <= dec_fmt_s;
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   // Saturating count of accepted instructions that matched no format.
   always_ff @(posedge clk) begin
      if (reset) begin
         unk_r <= '0;
      end else if (push_s && (dec_fmt_s == FMT_NONE) && (unk_r != {CNT_W{1'b1}})) begin
         unk_r <= unk_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         unk_r <= unk_r;
      end
   end

endmodule
